// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and defaults for the RV32I pipeline hazard control
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline <-> hazard controller signal bundle.
//               PERF_CNT_EN adds the performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
);

  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              loadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              mem_timeout;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cycles, flush_count;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output loadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_timeout
`ifdef PERF_CNT_EN
    ,
    input  stall_cycles, flush_count
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  loadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_timeout
`ifdef PERF_CNT_EN
    ,
    output stall_cycles, flush_count
`endif
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
// ============================================================================
// Module      : fwd_sel
// Description : Operand forwarding select for one Execute-stage source register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  // M is the younger producer, so it wins over W; x0 is never a real producer
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage RV32I hazard sequencer: forwarding, load-use stall,
//               branch flush, dmem wait stall with sticky timeout.
//               PERF_CNT_EN adds saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int INIT_BUBBLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int REG_AW       = REG_AW_DEFAULT
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int INIT_W = (INIT_BUBBLES > 1) ? $clog2(INIT_BUBBLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state, state_nxt;
  logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_q, timeout_nxt;

  logic     stall_f, stall_d, stall_e, stall_m;
  logic     flush_d, flush_e, flush_w;
  logic     pc_flush;
  logic     lwstall;
  logic     active;
  fwd_sel_t fwd_a, fwd_b;

  assign lwstall = hz.loadE && (hz.RdE != '0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign active  = rst_n && (state != INIT);

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (hz.Rs1E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .sel         (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (hz.Rs2E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .sel         (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= INIT_LOAD;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_q;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    pc_flush     = 1'b0;

    unique case (state)
      INIT: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_w = 1'b1;
        if (init_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          init_cnt_nxt = init_cnt - INIT_W'(1);
        end
      end

      RUN: begin
        // A missed dmem request freezes the whole pipe already in this cycle
        if (hz.MemReqM && !hz.dmem_ready) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = WAIT_W'(1);
          stall_f      = 1'b1;
          stall_d      = 1'b1;
          stall_e      = 1'b1;
          stall_m      = 1'b1;
          flush_w      = 1'b1;
        end else if (hz.PCSrcE) begin
          flush_d  = 1'b1;
          flush_e  = 1'b1;
          pc_flush = 1'b1;
        end else if (lwstall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      MWAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
        if (hz.dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_MAX) begin
          timeout_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase

    if (!rst_n) begin
      stall_f  = 1'b1;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      flush_w  = 1'b1;
      pc_flush = 1'b0;
    end
  end

  assign hz.ForwardAE   = active ? fwd_a : FWD_RF;
  assign hz.ForwardBE   = active ? fwd_b : FWD_RF;
  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_timeout = timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (active && stall_f && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (pc_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_count  = flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (directed + random traffic
//               against a cycle-level behavioural model). Honours PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int INIT_BUBBLES = 2;
  localparam int MEM_TIMEOUT  = 16;
  localparam int REG_AW       = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW)) hif ();

  hazard_ctrl #(
    .INIT_BUBBLES (INIT_BUBBLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .REG_AW       (REG_AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: bubbles still owed, whether a dmem access is outstanding,
  // how long it has been outstanding, and the sticky timeout flag.
  int bubbles_left = INIT_BUBBLES;
  bit in_wait      = 1'b0;
  int waited       = 0;
  bit tmo          = 1'b0;
  longint n_stall  = 0;
  longint n_flush  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
    if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE  = '0; hif.RdM  = '0; hif.RdW  = '0;
    hif.loadE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.dmem_ready = 1'b0;
  endtask

  task automatic set_random();
    hif.Rs1D = REG_AW'($urandom_range(0, 3));
    hif.Rs2D = REG_AW'($urandom_range(0, 3));
    hif.Rs1E = REG_AW'($urandom_range(0, 3));
    hif.Rs2E = REG_AW'($urandom_range(0, 3));
    hif.RdE  = REG_AW'($urandom_range(0, 3));
    hif.RdM  = REG_AW'($urandom_range(0, 3));
    hif.RdW  = REG_AW'($urandom_range(0, 3));
    hif.loadE      = ($urandom_range(0, 2) == 0);
    hif.RegWriteM  = ($urandom_range(0, 1) == 0);
    hif.RegWriteW  = ($urandom_range(0, 1) == 0);
    hif.PCSrcE     = ($urandom_range(0, 5) == 0);
    hif.MemReqM    = ($urandom_range(0, 4) == 0);
    hif.dmem_ready = ($urandom_range(0, 2) != 0);
    rst_n          = ($urandom_range(0, 299) != 0);
  endtask

  // Called right after inputs are driven on a negedge; checks outputs, then
  // advances the model across the following posedge.
  task automatic cycle(input string tag);
    bit         running, mem_hold, lw;
    logic [6:0] ctl;
    logic [11:0] exp_v, obs_v;
    #1;
    running  = rst_n && (bubbles_left == 0);
    mem_hold = running && (in_wait || (hif.MemReqM && !hif.dmem_ready));
    lw       = hif.loadE && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    // order: StallF StallD StallE StallM FlushD FlushE FlushW
    if (!running)        ctl = 7'b1000111;
    else if (mem_hold)   ctl = 7'b1111001;
    else if (hif.PCSrcE) ctl = 7'b0000110;
    else if (lw)         ctl = 7'b1100010;
    else                 ctl = 7'b0000000;
    exp_v = {running ? fwd_ref(hif.Rs1E) : 2'b00, running ? fwd_ref(hif.Rs2E) : 2'b00, ctl, tmo};
    obs_v = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE, hif.StallM,
             hif.FlushD, hif.FlushE, hif.FlushW, hif.mem_timeout};
    check_val(tag, 32'(obs_v), 32'(exp_v));
`ifdef PERF_CNT_EN
    check_val({tag, "_stall_cnt"}, 32'(hif.stall_cycles), 32'(n_stall));
    check_val({tag, "_flush_cnt"}, 32'(hif.flush_count), 32'(n_flush));
`endif
    if (!rst_n) begin
      bubbles_left = INIT_BUBBLES;
      in_wait = 1'b0; waited = 0; tmo = 1'b0;
      n_stall = 0; n_flush = 0;
    end else begin
      if (running && ctl[6]) n_stall++;
      if (running && !mem_hold && hif.PCSrcE) n_flush++;
      if (bubbles_left > 0) begin
        bubbles_left--;
      end else if (in_wait) begin
        if (!hif.dmem_ready && waited >= MEM_TIMEOUT) tmo = 1'b1;
        if (hif.dmem_ready) in_wait = 1'b0;
        else if (waited < MEM_TIMEOUT) waited++;
      end else if (hif.MemReqM && !hif.dmem_ready) begin
        in_wait = 1'b1;
        waited  = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);

    // reset, then release into the init bubbles and an idle running cycle
    cycle("rst0");
    cycle("rst1");
    rst_n = 1'b1;
    cycle("init_bubble1");
    cycle("init_bubble2");
    cycle("run_idle");

    // forwarding with M-over-W priority and x0 suppression
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5;
    hif.RegWriteW = 1'b1; hif.RdW = 5'd5; hif.Rs2E = 5'd5;
    cycle("fwd_m_w");
    check_val("fwd_a_is_m", 32'(hif.ForwardAE), 32'(2'b10));
    hif.RdM = 5'd0;
    cycle("fwd_rdm_x0");
    set_idle();

    // load-use stall, then branch flush overriding it
    hif.loadE = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    cycle("lwstall");
    hif.PCSrcE = 1'b1;
    cycle("branch_over_lw");
    hif.RdE = 5'd0; hif.Rs2D = 5'd0;
    cycle("lw_x0");
    set_idle();

    // three wait cycles then ready: four stalled cycles, released on the fifth
    hif.MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("mwait_%0d", i));
    hif.dmem_ready = 1'b1;
    cycle("mwait_ready");
    set_idle();
    cycle("mwait_released");
    check_val("no_timeout", 32'(hif.mem_timeout), 32'd0);

    // zero-wait access
    hif.MemReqM = 1'b1; hif.dmem_ready = 1'b1;
    cycle("mem_zero_wait");
    set_idle();

    // timeout: ready held low 20 cycles
    hif.MemReqM = 1'b1;
    cycle("tmo_enter");
    hif.MemReqM = 1'b0;
    for (int i = 1; i < 20; i++) cycle($sformatf("tmo_wait_%0d", i));
    hif.dmem_ready = 1'b1;
    cycle("tmo_ready");
    set_idle();
    for (int i = 0; i < 3; i++) cycle($sformatf("tmo_after_%0d", i));
    check_val("timeout_sticky", 32'(hif.mem_timeout), 32'd1);

    // reset in the middle of a wait
    hif.MemReqM = 1'b1;
    cycle("rst_mw_enter");
    hif.MemReqM = 1'b0;
    cycle("rst_mw_wait");
    rst_n = 1'b0;
    cycle("rst_mid_mwait");
    rst_n = 1'b1;
    check_val("rst_stallm_low", 32'(hif.StallM), 32'd0);
    check_val("rst_timeout_clr", 32'(hif.mem_timeout), 32'd0);
    cycle("post_rst_init1");
    cycle("post_rst_init2");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_random();
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
